// File: rtl/smol_pkg.sv
// rtl/smol_pkg.sv - shared constants and types for the SmolCore register file
// Contents:
//   XLEN_DEF, NREGS_DEF, AW_DEF : default data width, register count, address width
//   xword_t, reg_addr_t         : data word and register address types at default sizes
//   REG_ZERO                    : address of the hardwired-zero register x0
package smol_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [XLEN_DEF-1:0] xword_t;
   typedef logic [AW_DEF-1:0]   reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/smol_rf_scoreboard.sv
// rtl/smol_rf_scoreboard.sv - per-register busy scoreboard with reserve and write-clear
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (clears every busy bit)
//   rsv_en, rsv_addr  : reserve request, marks rsv_addr busy at the next edge
//   we, waddr         : the two writeback ports, an enabled write clears its target
//   busy              : scoreboard vector, bit 0 is always 0
module smol_rf_scoreboard
   import smol_pkg::*;
#(
   parameter  int NREGS = NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rsv_en,
   input  logic [AW-1:0]        rsv_addr,
   input  logic [1:0]           we,
   input  logic [1:0][AW-1:0]   waddr,
   output logic [NREGS-1:0]     busy
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // A reserve beats a write-clear on the same register: the new producer
   // has not delivered yet, so the register must stay busy.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < NREGS; r++) begin
         if (rsv_en && rsv_addr == AW'(r)) begin
            busy_d[r] = 1'b1;
         end else if ((we[0] && waddr[0] == AW'(r)) ||
                      (we[1] && waddr[1] == AW'(r))) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/smol_rf_mp.sv
// rtl/smol_rf_mp.sv - multi-port integer register file with busy scoreboard
// Optional feature macro: SMOL_RF_BYPASS_EN (zero-cycle write-to-read forwarding)
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ren, raddr            : per read port enable and address
//   rdata, rready         : per read port data (0 when disabled) and operand-valid
//   we, waddr, wdata      : two write ports, port 1 wins on an address collision
//   rsv_en, rsv_addr      : reserve a destination register (mark busy)
//   busy                  : scoreboard vector
module smol_rf_mp
   import smol_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   parameter  int NRP   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NRP-1:0]          ren,
   input  logic [NRP-1:0][AW-1:0]  raddr,
   output logic [NRP-1:0][XLEN-1:0] rdata,
   output logic [NRP-1:0]          rready,
   input  logic [1:0]              we,
   input  logic [1:0][AW-1:0]      waddr,
   input  logic [1:0][XLEN-1:0]    wdata,
   input  logic                    rsv_en,
   input  logic [AW-1:0]           rsv_addr,
   output logic [NREGS-1:0]        busy
);

   localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

   logic [XLEN-1:0] mem [NREGS];
   logic [1:0]      wr_ok;

   smol_rf_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .we       (we),
      .waddr    (waddr),
      .busy     (busy)
   );

   // x0 is never written; port 0 steps aside when port 1 hits the same register.
   always_comb begin
      wr_ok[1] = we[1] && (waddr[1] != ZERO);
      wr_ok[0] = we[0] && (waddr[0] != ZERO) && !(wr_ok[1] && waddr[1] == waddr[0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            mem[r] <= '0;
         end
      end else begin
         if (wr_ok[0]) mem[waddr[0]] <= wdata[0];
         if (wr_ok[1]) mem[waddr[1]] <= wdata[1];
      end
   end

   always_comb begin
      for (int p = 0; p < NRP; p++) begin
         rdata[p]  = '0;
         rready[p] = 1'b1;
         if (ren[p]) begin
            rdata[p]  = mem[raddr[p]];
            rready[p] = !busy[raddr[p]];
`ifdef SMOL_RF_BYPASS_EN
            if (raddr[p] != ZERO) begin
               if (we[1] && waddr[1] == raddr[p]) begin
                  rdata[p]  = wdata[1];
                  rready[p] = 1'b1;
               end else if (we[0] && waddr[0] == raddr[p]) begin
                  rdata[p]  = wdata[0];
                  rready[p] = 1'b1;
               end
            end
`endif
         end
      end
   end

endmodule
